// File: rtl/tnoc_address_map_pkg.sv
// Shared types for the NoC address map decoder: build configuration,
// region table entry and lookup result.
package tnoc_address_map_pkg;

  typedef struct packed {
    int address_width;
    int id_x_width;
    int id_y_width;
  } tnoc_config;

  localparam tnoc_config TNOC_DEFAULT_CONFIG = '{
    address_width: 32,
    id_x_width:    3,
    id_y_width:    3
  };

  localparam int TNOC_ADDRESS_WIDTH = TNOC_DEFAULT_CONFIG.address_width;
  localparam int TNOC_ID_X_WIDTH    = TNOC_DEFAULT_CONFIG.id_x_width;
  localparam int TNOC_ID_Y_WIDTH    = TNOC_DEFAULT_CONFIG.id_y_width;

  // Result region field is sized for the largest supported table.
  localparam int TNOC_MAX_REGIONS  = 16;
  localparam int TNOC_REGION_WIDTH = $clog2(TNOC_MAX_REGIONS);

  typedef logic [TNOC_ADDRESS_WIDTH-1:0] tnoc_address;

  typedef struct packed {
    logic [TNOC_ID_X_WIDTH-1:0] x;
    logic [TNOC_ID_Y_WIDTH-1:0] y;
  } tnoc_location_id;

  typedef struct packed {
    logic            enable;
    tnoc_address     base;
    tnoc_address     mask;
    tnoc_location_id id;
  } tnoc_address_region;

  typedef struct packed {
    tnoc_location_id              id;
    logic                         invalid;
    logic [TNOC_REGION_WIDTH-1:0] region;
  } tnoc_address_result;

  function automatic int region_index_width(input int regions);
    return (regions > 1) ? $clog2(regions) : 1;
  endfunction

endpackage

// File: rtl/tnoc_address_map_decoder_if.sv
// Bundle of the decoder's table-write, lookup request and response channels.
interface tnoc_address_map_decoder_if #(
  parameter int AW               = 32,
  parameter int XW               = 3,
  parameter int YW               = 3,
  parameter int IW               = 2,
  parameter int MISS_COUNT_WIDTH = 16
) ();

  logic                        i_cfg_valid;
  logic                        o_cfg_ready;
  logic [IW-1:0]               i_cfg_index;
  logic                        i_cfg_enable;
  logic [AW-1:0]               i_cfg_base;
  logic [AW-1:0]               i_cfg_mask;
  logic [XW-1:0]               i_cfg_id_x;
  logic [YW-1:0]               i_cfg_id_y;

  logic                        i_req_valid;
  logic                        o_req_ready;
  logic [AW-1:0]               i_req_address;

  logic                        o_rsp_valid;
  logic                        i_rsp_ready;
  logic [XW-1:0]               o_rsp_id_x;
  logic [YW-1:0]               o_rsp_id_y;
  logic                        o_rsp_invalid;
  logic [IW-1:0]               o_rsp_region;

  logic [MISS_COUNT_WIDTH-1:0] o_miss_count;

  modport master (
    output i_cfg_valid, i_cfg_index, i_cfg_enable, i_cfg_base, i_cfg_mask,
           i_cfg_id_x, i_cfg_id_y, i_req_valid, i_req_address, i_rsp_ready,
    input  o_cfg_ready, o_req_ready, o_rsp_valid, o_rsp_id_x, o_rsp_id_y,
           o_rsp_invalid, o_rsp_region, o_miss_count
  );

  modport slave (
    input  i_cfg_valid, i_cfg_index, i_cfg_enable, i_cfg_base, i_cfg_mask,
           i_cfg_id_x, i_cfg_id_y, i_req_valid, i_req_address, i_rsp_ready,
    output o_cfg_ready, o_req_ready, o_rsp_valid, o_rsp_id_x, o_rsp_id_y,
           o_rsp_invalid, o_rsp_region, o_miss_count
  );

endinterface

// File: rtl/tnoc_address_region_match.sv
// Single region comparator: hit when enabled and the masked address bits
// equal the masked base.
module tnoc_address_region_match
  import tnoc_address_map_pkg::*;
(
  input  logic        enable,
  input  tnoc_address base,
  input  tnoc_address mask,
  input  tnoc_address address,
  output logic        match
);

  assign match = enable && ((address & mask) == (base & mask));

endmodule

// File: rtl/tnoc_address_map_decoder.sv
// Programmable address-to-location decoder: region table, per-region compare,
// lowest-index priority select and a one-deep registered response.
module tnoc_address_map_decoder
  import tnoc_address_map_pkg::*;
#(
  parameter tnoc_config CONFIG           = TNOC_DEFAULT_CONFIG,
  parameter int         REGIONS          = 4,
  parameter int         MISS_COUNT_WIDTH = 16
)(
  input logic                       clk,
  input logic                       rst_n,
  tnoc_address_map_decoder_if.slave bus
);

  localparam int XW = CONFIG.id_x_width;
  localparam int YW = CONFIG.id_y_width;
  localparam int IW = region_index_width(REGIONS);

  tnoc_address_region          region_table [REGIONS];
  tnoc_address_region          cfg_entry;
  tnoc_address                 req_address;
  logic [REGIONS-1:0]          region_match;
  tnoc_address_result          lookup_result;
  tnoc_address_result          rsp_q;
  logic                        rsp_valid;
  logic                        req_ready;
  logic                        req_accept;
  logic                        rsp_transfer;
  logic [MISS_COUNT_WIDTH-1:0] miss_count;
  logic                        unused_region_bits;

  always_comb begin
    cfg_entry        = '0;
    cfg_entry.enable = bus.i_cfg_enable;
    cfg_entry.base   = TNOC_ADDRESS_WIDTH'(bus.i_cfg_base);
    cfg_entry.mask   = TNOC_ADDRESS_WIDTH'(bus.i_cfg_mask);
    cfg_entry.id.x   = TNOC_ID_X_WIDTH'(bus.i_cfg_id_x);
    cfg_entry.id.y   = TNOC_ID_Y_WIDTH'(bus.i_cfg_id_y);
  end

  // Indices with no matching entry simply fall through, so out-of-range
  // writes are accepted and dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < REGIONS; r++) begin
        region_table[r] <= '0;
      end
    end else if (bus.i_cfg_valid) begin
      for (int r = 0; r < REGIONS; r++) begin
        if (bus.i_cfg_index == IW'(r)) begin
          region_table[r] <= cfg_entry;
        end
      end
    end
  end

  assign req_address = TNOC_ADDRESS_WIDTH'(bus.i_req_address);

  for (genvar g = 0; g < REGIONS; g++) begin : g_region
    tnoc_address_region_match u_match (
      .enable  (region_table[g].enable),
      .base    (region_table[g].base),
      .mask    (region_table[g].mask),
      .address (req_address),
      .match   (region_match[g])
    );
  end

  // Walk from the top so the lowest matching index is the last to win.
  always_comb begin
    lookup_result         = '0;
    lookup_result.invalid = 1'b1;
    for (int r = REGIONS - 1; r >= 0; r--) begin
      if (region_match[r]) begin
        lookup_result.id      = region_table[r].id;
        lookup_result.invalid = 1'b0;
        lookup_result.region  = TNOC_REGION_WIDTH'(r);
      end
    end
  end

  assign req_ready    = !rsp_valid || bus.i_rsp_ready;
  assign req_accept   = bus.i_req_valid && req_ready;
  assign rsp_transfer = rsp_valid && bus.i_rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_q      <= '0;
      miss_count <= '0;
    end else begin
      if (req_accept) begin
        rsp_valid <= 1'b1;
        rsp_q     <= lookup_result;
      end else if (bus.i_rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      if (rsp_transfer && rsp_q.invalid && (miss_count != '1)) begin
        miss_count <= miss_count + MISS_COUNT_WIDTH'(1);
      end
    end
  end

  assign bus.o_cfg_ready   = 1'b1;
  assign bus.o_req_ready   = req_ready;
  assign bus.o_rsp_valid   = rsp_valid;
  assign bus.o_rsp_id_x    = XW'(rsp_q.id.x);
  assign bus.o_rsp_id_y    = YW'(rsp_q.id.y);
  assign bus.o_rsp_invalid = rsp_q.invalid;
  assign bus.o_rsp_region  = rsp_q.region[IW-1:0];
  assign bus.o_miss_count  = miss_count;

  assign unused_region_bits = ^rsp_q.region;

endmodule

// File: doc/tnoc_address_map_decoder.md
TNOC_ADDRESS_MAP_DECODER -- requirements
Module: tnoc_address_map_decoder

Interface
REQ-001 Parameter CONFIG, default TNOC_DEFAULT_CONFIG, supplies address_width (AW), id_x_width (XW), id_y_width (YW).
REQ-002 Parameter REGIONS, default 4, range 1..16: number of programmable address regions.
REQ-003 Parameter MISS_COUNT_WIDTH, default 16: width of the saturating miss counter.
REQ-004 Derived IW = max(1, $clog2(REGIONS)): region index width.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-007 i_cfg_valid  input  1  region-table write strobe.
REQ-008 o_cfg_ready  output  1  table write accepted.
REQ-009 i_cfg_index  input  IW  region entry to write.
REQ-010 i_cfg_enable / i_cfg_base / i_cfg_mask  input  1 / AW / AW  entry enable, base address, compare mask.
REQ-011 i_cfg_id_x / i_cfg_id_y  input  XW / YW  destination location id for the entry.
REQ-012 i_req_valid / o_req_ready / i_req_address  in / out / in  1 / 1 / AW  lookup request channel.
REQ-013 o_rsp_valid / i_rsp_ready  out / in  1 / 1  lookup response handshake.
REQ-014 o_rsp_id_x / o_rsp_id_y / o_rsp_invalid / o_rsp_region  output  XW / YW / 1 / IW  decode result.
REQ-015 o_miss_count  output  MISS_COUNT_WIDTH  number of responses issued with invalid set.

Function
REQ-016 Entry r matches address A when enable[r] is 1 and (A & mask[r]) == (base[r] & mask[r]).
REQ-017 When several entries match, the lowest index wins; o_rsp_region returns that index.
REQ-018 When no entry matches, the response has o_rsp_invalid = 1, id_x = 0, id_y = 0, region = 0.
REQ-019 A request transfers when i_req_valid && o_req_ready; its response is presented with o_rsp_valid = 1 on the next cycle (latency 1).
REQ-020 o_req_ready = !o_rsp_valid || i_rsp_ready, so back-to-back lookups sustain one per cycle.
REQ-021 While o_rsp_valid = 1 and i_rsp_ready = 0, all o_rsp_* outputs hold stable.
REQ-022 o_rsp_valid clears on the cycle after a response transfer with no new request accepted.
REQ-023 o_cfg_ready is constantly 1; a table write takes effect on the clock edge where it transfers.
REQ-024 A lookup accepted in the same cycle as a table write decodes against the pre-write table.
REQ-025 A write with i_cfg_index >= REGIONS is accepted and discarded; no entry changes.
REQ-026 A mask of all zeros matches every address while the entry is enabled.
REQ-027 o_miss_count increments by 1 on each response transfer with o_rsp_invalid = 1 and saturates at all-ones without wrapping.

Reset
REQ-028 While rst_n = 0: all entries have enable = 0 and base = mask = id = 0; o_rsp_valid = 0; o_rsp_* = 0; o_miss_count = 0.
REQ-029 An assertion of rst_n mid-transfer discards the pending response with no residual valid.
REQ-030 o_cfg_ready and o_req_ready equal 1 during reset and on the first cycle after rst_n deasserts.

Structure
REQ-031 The region entry struct (enable, base, mask, location id) and the result struct (location id, invalid, region) are defined in a shared package, tnoc_address_map_pkg, parameterised on the widths from CONFIG.
REQ-032 The per-entry comparator is a sub-module, tnoc_address_region_match, instantiated REGIONS times through a generate loop.
REQ-033 The priority select and the response register reside in tnoc_address_map_decoder itself; there are no latches and no combinational path from i_rsp_ready to o_rsp_*.

Verification
REQ-034 Program entry 0 with base 0x0, mask top 2 bits, id (1,0); look up address 0x0 -> next cycle valid=1, id (1,0), invalid=0, region 0.
REQ-035 Enable entry 1 (mask 0) and entry 2 (overlapping match) -> region 1 is returned, confirming lowest-index priority.
REQ-036 Look up with every entry disabled -> invalid=1, id (0,0); o_miss_count goes 0 -> 1.
REQ-037 Hold i_rsp_ready=0 for 3 cycles with i_req_valid=1 -> o_req_ready=0 and the response stays stable; on release, one lookup per cycle for 4 cycles.
REQ-038 Write entry 0 in the same cycle as a lookup of a matching address -> that response uses the old entry; the next lookup uses the new one.
REQ-039 Issue 2^MISS_COUNT_WIDTH+2 misses (MISS_COUNT_WIDTH=4 build) -> o_miss_count holds at 15; asserting rst_n=0 mid-response drops o_rsp_valid immediately.
